// File: rtl/alu_defs.sv
// Shared definitions for the ALU arbiter: opcode constants, datapath widths
// and the arbiter FSM state encoding.
package alu_defs;

  localparam int OP_W   = 5;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response channels of the shared-ALU arbiter.
// Requester i owns bit i of each vector and slice i of the packed operand buses.
interface alu_arbiter_if
  import alu_defs::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [OP_W*NUM_REQ-1:0]   req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_ready;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request found
// searching upward from last_grant+1, wrapping at N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [GW-1:0] grant_idx,
  output logic          any_req
);

  logic found;
  int   cand;

  // NOTE: combinational blocks use blocking assignments and give every
  // assigned variable a default at the top, so no latch can be inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == cand) && req[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = GW'(i);
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational 8-bit ALU between NUM_REQ requesters:
// round-robin grant, latch operands, drive the ALU for one cycle, return result.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      req_if,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  state_t              state, state_n;
  logic [GW-1:0]       last_grant, grant_r, pick_idx;
  logic [NUM_REQ-1:0]  pick_oh, rsp_valid_c;
  logic                any_req, rsp_ack;
  logic [OP_W-1:0]     op_r, sel_op;
  logic [DATA_W-1:0]   a_r, b_r, sel_a, sel_b, rsp_data_r;

  rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_rr (
    .req        (req_if.req_valid),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_idx),
    .any_req    (any_req)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_op = req_if.req_op[i*OP_W +: OP_W];
        sel_a  = req_if.req_a[i*DATA_W +: DATA_W];
        sel_b  = req_if.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rsp_valid_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == RESP) && (grant_r == GW'(i))) rsp_valid_c[i] = 1'b1;
    end
  end

  // Only the granted requester's rsp_ready can complete the response.
  assign rsp_ack = |(rsp_valid_c & req_if.rsp_ready);

  // Gated by rst_n so no handshake is advertised while reset is held.
  assign req_if.req_ready = ((state == IDLE) && rst_n) ? pick_oh : '0;
  assign req_if.rsp_valid = rsp_valid_c;
  assign req_if.rsp_data  = rsp_data_r;
  assign busy             = (state != IDLE);

  // The operand registers only change on acceptance, which always enters EXEC,
  // so they drive the ALU directly and hold their values in other states.
  assign alu_op = op_r;
  assign alu_a  = a_r;
  assign alu_b  = b_r;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (rsp_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant_r    <= '0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      rsp_data_r <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          op_r    <= sel_op;
          a_r     <= sel_a;
          b_r     <= sel_b;
          grant_r <= pick_idx;
        end
        EXEC:    rsp_data_r <= alu_result;
        RESP:    if (rsp_ack) last_grant <= grant_r;
        default: ;
      endcase
    end
  end

endmodule
